// File: rtl/window_buf_pingpong_if.sv
// window_buf_pingpong_if: streaming write port and multi-port frame read bus
interface window_buf_pingpong_if #(
  parameter int DEPTH        = 1024,
  parameter int WIDTH        = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int OUT_PORT_NUM = 25
);
  localparam int AW = $clog2(DEPTH);
  logic                             wr_valid;
  logic                             wr_ready;
  logic [WIDTH-1:0]                 wr_data;
  logic                             wr_last;
  logic                             rd_bank_ready;
  logic [AW:0]                      rd_frame_len;
  logic                             rd_en;
  logic [OUT_PORT_NUM*ADDR_WIDTH-1:0] rd_addr_NP;
  logic [OUT_PORT_NUM*WIDTH-1:0]    rd_data_NP;
  logic                             rd_data_valid;
  logic                             rd_done;
  logic                             err;
  modport master (
    output wr_valid, wr_data, wr_last, rd_en, rd_addr_NP, rd_done,
    input  wr_ready, rd_bank_ready, rd_frame_len, rd_data_NP, rd_data_valid, err
  );
  modport slave (
    input  wr_valid, wr_data, wr_last, rd_en, rd_addr_NP, rd_done,
    output wr_ready, rd_bank_ready, rd_frame_len, rd_data_NP, rd_data_valid, err
  );
endinterface

// File: rtl/window_buf_pingpong.sv
// window_buf_pingpong: two-bank frame buffer, one streaming writer, many registered read ports
module window_buf_pingpong #(
  parameter int DEPTH        = 1024,
  parameter int WIDTH        = 16,
  parameter int ADDR_WIDTH   = 32,
  parameter int OUT_PORT_NUM = 25
) (
  input logic clk,
  input logic rst,
  window_buf_pingpong_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;

  logic [WIDTH-1:0]      mem [2][DEPTH];
  logic [1:0]            st [2];
  logic [AW:0]           len [2];
  logic                  wb, rb, rst_d;
  logic [AW-1:0]         wr_ptr;
  logic [ADDR_WIDTH-1:0] addr [OUT_PORT_NUM];
  logic [OUT_PORT_NUM-1:0] oob;
  logic [WIDTH-1:0]      rd_q [OUT_PORT_NUM];
  logic                  wr_rdy, wr_acc, closing, rd_ready, rd_acc, done_acc, err_q, valid_q;

  assign wr_rdy   = !rst_d && st[wb] != FULL;
  assign wr_acc   = bus.wr_valid && wr_rdy;
  assign closing  = wr_acc && (bus.wr_last || &wr_ptr);
  assign rd_ready = st[rb] == FULL;
  assign rd_acc   = bus.rd_en && rd_ready;
  assign done_acc = bus.rd_done && rd_ready;

  assign bus.wr_ready      = wr_rdy;
  assign bus.rd_bank_ready = rd_ready;
  assign bus.rd_frame_len  = rd_ready ? len[rb] : '0;
  assign bus.rd_data_valid = valid_q;
  assign bus.err           = err_q;

  // unpack per-port addresses and flag those beyond the bank
  always_comb begin
    for (int j = 0; j < OUT_PORT_NUM; j++) begin
      addr[j] = bus.rd_addr_NP[j*ADDR_WIDTH +: ADDR_WIDTH];
      oob[j]  = addr[j] >= ADDR_WIDTH'(DEPTH);
    end
  end

  generate
    for (genvar i = 0; i < OUT_PORT_NUM; i++) begin : g_pack
      assign bus.rd_data_NP[i*WIDTH +: WIDTH] = rd_q[i];
    end
  endgenerate

  // storage write; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wb][wr_ptr] <= bus.wr_data;
  end

  // bank state machine, pointers and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      st[0]   <= EMPTY;
      st[1]   <= EMPTY;
      len[0]  <= '0;
      len[1]  <= '0;
      wb      <= 1'b0;
      rb      <= 1'b0;
      wr_ptr  <= '0;
      rst_d   <= 1'b1;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rst_d   <= 1'b0;
      valid_q <= rd_acc;
      if (wr_acc) begin
        st[wb] <= closing ? FULL : FILLING;
        wr_ptr <= closing ? '0 : wr_ptr + 1'b1;
      end
      if (closing) begin
        len[wb] <= {1'b0, wr_ptr} + 1'b1;
        wb      <= ~wb;
      end
      if (done_acc) begin
        st[rb] <= EMPTY;
        rb     <= ~rb;
      end
      if (((bus.rd_en || bus.rd_done) && !rd_ready) || (rd_acc && |oob)) err_q <= 1'b1;
    end
  end

  // registered read data for every port from the presented bank
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < OUT_PORT_NUM; j++) rd_q[j] <= '0;
    end else if (rd_acc) begin
      for (int j = 0; j < OUT_PORT_NUM; j++) rd_q[j] <= oob[j] ? '0 : mem[rb][addr[j][AW-1:0]];
    end
  end
endmodule
